result_store_queue: RTL
=======================

# result_store_queue

Four-entry, 16-bit first-in-first-out staging queue between the ALU result bus and the 16-bit cache register. It accepts ALU results through a valid/ready handshake and drains them one per cycle when the cache side permits. Each drained word is presented as a registered data word plus a one-cycle store strobe. The strobe drives the cache register's `storage_activator` input and the word drives its `data_in`.

## Interface

Parameters:
- `WIDTH`, default 16: data word width; must match the cache register width.
- `DEPTH`, default 4: number of entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1 bit: single clock; all state changes on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `in_data`, input, `WIDTH` bits: ALU result word.
- `in_valid`, input, 1 bit: `in_data` is valid this cycle.
- `in_ready`, output, 1 bit: queue can accept this cycle; equals `!full`; combinational from state only.
- `drain_en`, input, 1 bit: cache side permits one store this cycle.
- `store_data`, output, `WIDTH` bits: word to cache `data_in`; registered.
- `store_en`, output, 1 bit: one-cycle strobe to cache `storage_activator`; registered.
- `count`, output, `$clog2(DEPTH)+1` bits: current occupancy, 0..`DEPTH`.
- `full`, output, 1 bit: `count == DEPTH`.
- `empty`, output, 1 bit: `count == 0`.
- `overflow`, output, 1 bit: sticky flag; set when `in_valid` is high while `full` is high.

## Operation

- Storage is an array of `DEPTH` × `WIDTH` words with a write pointer `wp`, a read pointer `rp` and an occupancy counter.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH` (3 → 0 for `DEPTH` = 4).
- **Push:** occurs when `in_valid && in_ready`.
  - `mem[wp] <= in_data`, then `wp` increments.
- **Pop:** occurs when `drain_en && !empty`, where `empty` is evaluated on the pre-edge state.
  - `store_data <= mem[rp]`, `store_en <= 1`, then `rp` increments.
- **No pop:** `store_en <= 0` and `store_data` holds its last value.
- **Push and pop in the same cycle:** both happen and `count` is unchanged.
- **Full:** `in_ready` is 0, so no push occurs, even if a pop occurs in the same cycle. There is no pass-through when full.
- **Empty:** no pop occurs, even if a push occurs in the same cycle. There is no bypass; a pushed word is poppable from the next cycle.
- **Overflow:** when `in_valid` is high while `full` is high, the word is dropped and `overflow <= 1`. The flag stays set until `rst`.
- **Reset:** `rst` has priority over all push and pop activity in the same cycle. Reset values:
  - `wp` = 0, `rp` = 0, `count` = 0.
  - `store_en` = 0, `store_data` = 0, `overflow` = 0.
  - Hence `empty` = 1, `full` = 0, `in_ready` = 1.
  - Memory contents are not cleared; they are unobservable until rewritten.
- **Reset mid-stream:** all queued words are discarded. A `store_en` that was high in the reset cycle is low in the following cycle.

## Timing

- Push latency: a word pushed at edge N is poppable at edge N+1.
- Pop latency: `drain_en` sampled high at edge N (queue non-empty) gives `store_en` = 1 and `store_data` = word in the cycle after edge N. The cache register captures it while the strobe is high.
- Minimum input-to-cache latency: 2 cycles (push edge, then pop edge).
- Throughput: one push and one pop per cycle sustained.
- `store_en` is never high for two consecutive cycles unless `drain_en` is high on both corresponding edges and the queue is non-empty at each.
- `in_ready`, `full`, `empty` and `count` reflect state after the most recent edge; they are not combinational from this cycle's inputs.
- Ordering is strictly FIFO. No word is duplicated or lost, except words dropped on overflow.

## Test plan

1. **Reset values:** hold `rst` for 2 cycles, then release → `count` = 0, `empty` = 1, `in_ready` = 1, `store_en` = 0, `store_data` = 0, `overflow` = 0.
2. **Fill:** push 0x0001, 0x0002, 0x0003, 0x0004 with `drain_en` = 0 → `full` = 1, `in_ready` = 0. Push 0x0005 → `overflow` = 1, `count` = 4. Then hold `drain_en` = 1 for 4 cycles → `store_en` pulses 4 times with 0x0001..0x0004 in order, then `empty` = 1. 0x0005 never appears.
3. **Empty with push and drain:** queue empty, push 0xAAAA with `drain_en` = 1 in the same cycle → no `store_en` next cycle, `count` = 1. Next cycle `drain_en` = 1 → `store_en` = 1 with `store_data` = 0xAAAA.
4. **Streaming and wrap-around:** push 10 words 0x0100..0x0109 continuously with `drain_en` = 1 throughout → `store_data` sequence 0x0100..0x0109, each with `store_en` = 1. Pointers wrap at least twice. `count` stays ≤ 1 after fill-up.
5. **Full with push and pop:** queue full, `in_valid` = 1 and `drain_en` = 1 → oldest word is popped, the new word is not accepted, `count` = 3, `overflow` = 1.
6. **Reset mid-operation:** 3 words queued, assert `rst` together with `in_valid` and `drain_en` → next cycle `count` = 0, `store_en` = 0, `overflow` = 0. A subsequent push/drain of 0x1234 yields 0x1234 with no stale data.

Source files
------------

// File: rtl/result_store_queue.sv
// Four-entry staging FIFO between the ALU result bus and the cache register.
// Each drained word is presented as a registered data word plus a one-cycle store strobe.
module result_store_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       drain_en,
    output logic [WIDTH-1:0]           store_data,
    output logic                       store_en,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic             push;
    logic             pop;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on registered occupancy, never on this cycle's inputs.
    // A valid word offered while full is dropped and latches the sticky overflow flag.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = drain_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            store_en   <= 1'b0;
            store_data <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                store_data <= mem[rp];
                rp         <= rp + PW'(1);
            end
            store_en <= pop;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is not cleared on reset; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wp] <= in_data;
        end
    end

endmodule
